// File: rtl/mem_access_ctrl.sv
// Multicycle load/store sequencer between the main control FSM and the memory/MDR datapath.
// Optional alignment rejection is compiled in with `define MEM_ALIGN_CHECK_EN.
module mem_access_ctrl #(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_store,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic        mdr_load,
  output logic [1:0]  ls_ctrl,
  output logic [1:0]  ss_ctrl,
  output logic        rf_write,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE, RD_WAIT, LATCH, LOAD_WB, STORE_WR, ERR
  } state_e;

  localparam logic [1:0] SZ_WORD = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [3:0] LAT_INIT = 4'(MEM_LAT);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        store_q, store_d;
  logic        req_bad;

  always_comb begin
    req_bad = (size == 2'b00);
`ifdef MEM_ALIGN_CHECK_EN
    if ((size == SZ_WORD) && (addr[1:0] != 2'b00)) req_bad = 1'b1;
    if ((size == SZ_HALF) && addr[0])              req_bad = 1'b1;
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    size_d  = size_q;
    store_d = store_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d  = addr;
          size_d  = size;
          store_d = is_store;
          if (req_bad) begin
            state_d = ERR;
          end else if (is_store && (size == SZ_WORD)) begin
            state_d = STORE_WR;
          end else begin
            state_d = RD_WAIT;
            cnt_d   = LAT_INIT;
          end
        end
      end
      RD_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = LATCH;
      end
      // Sub-word stores read the word first so the store-size mux can merge into it.
      LATCH:    state_d = store_q ? STORE_WR : LOAD_WB;
      LOAD_WB:  state_d = IDLE;
      STORE_WR: state_d = IDLE;
      ERR:      state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request payload needs no reset: every output that uses it is gated by state.
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    size_q  <= size_d;
    store_q <= store_d;
  end

  always_comb begin
    mem_addr = 32'd0;
    mem_wr   = 1'b0;
    mdr_load = 1'b0;
    ls_ctrl  = 2'b00;
    ss_ctrl  = 2'b00;
    rf_write = 1'b0;
    busy     = (state_q != IDLE);
    done     = 1'b0;
    err      = 1'b0;
    case (state_q)
      RD_WAIT: mem_addr = addr_q;
      LATCH: begin
        mem_addr = addr_q;
        mdr_load = 1'b1;
      end
      LOAD_WB: begin
        mem_addr = addr_q;
        ls_ctrl  = size_q;
        rf_write = 1'b1;
        done     = 1'b1;
      end
      STORE_WR: begin
        mem_addr = addr_q;
        mem_wr   = 1'b1;
        ss_ctrl  = size_q;
        done     = 1'b1;
      end
      ERR: begin
        done = 1'b1;
        err  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: one instance with MEM_LAT=1, one with MEM_LAT=3.
// Expectations for the misaligned-halfword case follow `MEM_ALIGN_CHECK_EN.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;

  logic        start_a, st_a, start_b, st_b;
  logic [1:0]  size_a, size_b;
  logic [31:0] addr_a, addr_b;
  logic [31:0] mem_addr_a, mem_addr_b;
  logic        mem_wr_a, mdr_load_a, rf_a, busy_a, done_a, err_a;
  logic        mem_wr_b, mdr_load_b, rf_b, busy_b, done_b, err_b;
  logic [1:0]  ls_a, ss_a, ls_b, ss_b;
  logic [9:0]  obs_a, obs_b;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.MEM_LAT(1)) u_dut_a (
    .clk(clk), .reset(reset), .start(start_a), .is_store(st_a), .size(size_a),
    .addr(addr_a), .mem_addr(mem_addr_a), .mem_wr(mem_wr_a), .mdr_load(mdr_load_a),
    .ls_ctrl(ls_a), .ss_ctrl(ss_a), .rf_write(rf_a), .busy(busy_a), .done(done_a),
    .err(err_a)
  );

  mem_access_ctrl #(.MEM_LAT(3)) u_dut_b (
    .clk(clk), .reset(reset), .start(start_b), .is_store(st_b), .size(size_b),
    .addr(addr_b), .mem_addr(mem_addr_b), .mem_wr(mem_wr_b), .mdr_load(mdr_load_b),
    .ls_ctrl(ls_b), .ss_ctrl(ss_b), .rf_write(rf_b), .busy(busy_b), .done(done_b),
    .err(err_b)
  );

  // Packed view: {mem_wr, mdr_load, ls_ctrl, ss_ctrl, rf_write, busy, done, err}
  assign obs_a = {mem_wr_a, mdr_load_a, ls_a, ss_a, rf_a, busy_a, done_a, err_a};
  assign obs_b = {mem_wr_b, mdr_load_b, ls_b, ss_b, rf_b, busy_b, done_b, err_b};

  localparam logic [9:0] O_IDLE  = 10'b0_0_00_00_0_0_0_0;
  localparam logic [9:0] O_WAIT  = 10'b0_0_00_00_0_1_0_0;
  localparam logic [9:0] O_LATCH = 10'b0_1_00_00_0_1_0_0;
  localparam logic [9:0] O_ERR   = 10'b0_0_00_00_0_1_1_1;

  function automatic logic [9:0] o_ldwb(input logic [1:0] sz);
    return {1'b0, 1'b0, sz, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0};
  endfunction

  function automatic logic [9:0] o_stwr(input logic [1:0] sz);
    return {1'b1, 1'b0, 2'b00, sz, 1'b0, 1'b1, 1'b1, 1'b0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_o(input string tag, input logic [9:0] got, input logic [9:0] exp);
    chk(tag, {22'd0, got}, {22'd0, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int wr_cnt;
    int done_cnt;
    logic [9:0] e;

    reset   = 1'b0;
    start_a = 1'b0; st_a = 1'b0; size_a = 2'b00; addr_a = 32'd0;
    start_b = 1'b0; st_b = 1'b0; size_b = 2'b00; addr_b = 32'd0;
    #12;
    chk_o("reset_outs_a", obs_a, O_IDLE);
    chk_o("reset_outs_b", obs_b, O_IDLE);
    chk("reset_addr_a", mem_addr_a, 32'd0);
    tick();
    reset = 1'b1;
    tick();

    // Load word, MEM_LAT=1
    start_a = 1'b1; st_a = 1'b0; size_a = 2'b01; addr_a = 32'h10;
    for (int k = 1; k <= 4; k++) begin
      tick();
      start_a = 1'b0;
      e = (k == 1) ? O_WAIT : (k == 2) ? O_LATCH : (k == 3) ? o_ldwb(2'b01) : O_IDLE;
      chk_o($sformatf("ld_w_c%0d", k), obs_a, e);
      chk($sformatf("ld_w_addr_c%0d", k), mem_addr_a, (k <= 3) ? 32'h10 : 32'h0);
    end

    // Byte store (read-modify-write), MEM_LAT=3
    start_b = 1'b1; st_b = 1'b1; size_b = 2'b11; addr_b = 32'h21;
    wr_cnt = 0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      start_b = 1'b0;
      wr_cnt += int'(mem_wr_b);
      e = (k <= 3) ? O_WAIT : (k == 4) ? O_LATCH : (k == 5) ? o_stwr(2'b11) : O_IDLE;
      chk_o($sformatf("st_b_c%0d", k), obs_b, e);
      chk($sformatf("st_b_addr_c%0d", k), mem_addr_b, (k <= 5) ? 32'h21 : 32'h0);
    end
    chk("st_b_wr_pulses", wr_cnt, 1);

    // Word store goes straight to the write
    start_a = 1'b1; st_a = 1'b1; size_a = 2'b01; addr_a = 32'h40;
    tick();
    start_a = 1'b0;
    chk_o("st_w_c1", obs_a, o_stwr(2'b01));
    chk("st_w_addr_c1", mem_addr_a, 32'h40);
    tick();
    chk_o("st_w_c2", obs_a, O_IDLE);

    // Illegal size
    start_a = 1'b1; st_a = 1'b0; size_a = 2'b00; addr_a = 32'h8;
    tick();
    start_a = 1'b0;
    chk_o("sz0_c1", obs_a, O_ERR);
    chk("sz0_addr_c1", mem_addr_a, 32'h0);
    tick();
    chk_o("sz0_c2", obs_a, O_IDLE);

    // Misaligned halfword load
    start_a = 1'b1; st_a = 1'b0; size_a = 2'b10; addr_a = 32'h3;
`ifdef MEM_ALIGN_CHECK_EN
    tick();
    start_a = 1'b0;
    chk_o("mis_h_c1", obs_a, O_ERR);
    chk("mis_h_addr_c1", mem_addr_a, 32'h0);
    tick();
    chk_o("mis_h_c2", obs_a, O_IDLE);
`else
    for (int k = 1; k <= 4; k++) begin
      tick();
      start_a = 1'b0;
      e = (k == 1) ? O_WAIT : (k == 2) ? O_LATCH : (k == 3) ? o_ldwb(2'b10) : O_IDLE;
      chk_o($sformatf("mis_h_c%0d", k), obs_a, e);
      chk($sformatf("mis_h_addr_c%0d", k), mem_addr_a, (k <= 3) ? 32'h3 : 32'h0);
    end
`endif

    // Reset in the middle of a byte store wait
    start_b = 1'b1; st_b = 1'b1; size_b = 2'b11; addr_b = 32'h55;
    tick();
    start_b = 1'b0;
    tick();
    chk_o("rst_pre", obs_b, O_WAIT);
    reset = 1'b0;
    #1;
    chk_o("rst_async_outs", obs_b, O_IDLE);
    chk("rst_async_addr", mem_addr_b, 32'h0);
    wr_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      wr_cnt += int'(mem_wr_b);
    end
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      wr_cnt += int'(mem_wr_b);
      chk_o($sformatf("rst_after_c%0d", k), obs_b, O_IDLE);
    end
    chk("rst_no_wr", wr_cnt, 0);

    start_b = 1'b1; st_b = 1'b0; size_b = 2'b11; addr_b = 32'h7;
    for (int k = 1; k <= 6; k++) begin
      tick();
      start_b = 1'b0;
      e = (k <= 3) ? O_WAIT : (k == 4) ? O_LATCH : (k == 5) ? o_ldwb(2'b11) : O_IDLE;
      chk_o($sformatf("ld_b_c%0d", k), obs_b, e);
    end
    chk("ld_b_addr_after", mem_addr_b, 32'h0);

    // start held high: accepted at cycles 0, 4, 8
    start_a = 1'b1; st_a = 1'b0; size_a = 2'b01; addr_a = 32'h100;
    done_cnt = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      done_cnt += int'(done_a);
      chk($sformatf("b2b_done_c%0d", k), {31'd0, done_a}, {31'd0, (k % 4) == 3});
      chk($sformatf("b2b_busy_c%0d", k), {31'd0, busy_a}, {31'd0, (k % 4) != 0});
    end
    start_a = 1'b0;
    tick();
    done_cnt += int'(done_a);
    chk_o("b2b_c11", obs_a, o_ldwb(2'b01));
    tick();
    chk_o("b2b_c12", obs_a, O_IDLE);
    chk("b2b_done_count", done_cnt, 3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Multicycle sequencer for data-memory accesses: latches a load/store request from the main control unit, drives the memory address and write strobe, waits out the memory read latency, pulses the MDR load, and drives the load-size and store-size selectors at the correct cycle. Sits between the main control FSM and the memory/MDR/load-size/store-size datapath. Sub-word stores are performed as read-modify-write.

## Interface
- MEM_LAT, 1: cycles from `mem_addr` valid to `mem_rdata` valid in MDR input; legal 1..15
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low
- start  in  1  request strobe, sampled only in IDLE
- is_store  in  1  1 = store, 0 = load
- size  in  2  01 word, 10 halfword, 11 byte, 00 illegal
- addr  in  32  byte address
- mem_addr  out  32  address to memory
- mem_wr  out  1  memory write strobe
- mdr_load  out  1  MDR write enable
- ls_ctrl  out  2  load-size select (same encoding as `size`)
- ss_ctrl  out  2  store-size select (same encoding)
- rf_write  out  1  register-file write enable for load result
- busy  out  1  request in progress
- done  out  1  one-cycle completion pulse
- err  out  1  qualifies `done`: request rejected

## Operation
- States: IDLE, RD_WAIT, LATCH, LOAD_WB, STORE_WR, ERR.
- IDLE: `start`=1 latches `is_store`, `size`, `addr`; `start` ignored in every other state.
- From IDLE on start: size=00 (or misaligned, see Configuration) -> ERR; word store -> STORE_WR; else -> RD_WAIT with counter loaded to MEM_LAT.
- RD_WAIT: `mem_addr`=latched addr, counter decrements; at counter=1 -> LATCH.
- LATCH: `mdr_load`=1 one cycle; -> LOAD_WB (load) or STORE_WR (sub-word store).
- LOAD_WB: `ls_ctrl`=latched size, `rf_write`=1, `done`=1; -> IDLE.
- STORE_WR: `mem_addr`=latched addr, `mem_wr`=1, `ss_ctrl`=latched size (01 for word), `done`=1; -> IDLE.
- ERR: `done`=1, `err`=1, no `mem_wr`, no `rf_write`; -> IDLE.
- `busy`=1 in every state except IDLE.
- All outputs registered-state decodes (Moore); no combinational path from `start` to outputs.

## Timing
- Reset (async, any state): state=IDLE, counter=0, all outputs 0, `mem_addr`=0; pending access abandoned, no write issued after reset asserts.
- `ls_ctrl`, `ss_ctrl` = 00 outside LOAD_WB / STORE_WR.
- `mem_addr` holds latched addr from RD_WAIT through STORE_WR; 0 in IDLE/ERR.
- Load: start at edge E0; RD_WAIT for MEM_LAT cycles; LATCH; `done` in cycle MEM_LAT+2 after E0. MEM_LAT=1 -> done 3 cycles after start.
- Sub-word store: same as load, `done`+`mem_wr` in cycle MEM_LAT+2.
- Word store: `done`+`mem_wr` in cycle 1 after E0.
- ERR: `done`+`err` in cycle 1 after E0.
- Back-to-back: `start` held high re-accepted the cycle after `done` (IDLE revisited for exactly one cycle).

## Configuration
- `MEM_ALIGN_CHECK_EN` defined: word with addr[1:0]≠00 or halfword with addr[0]=1 -> ERR, memory untouched.
- Undefined: no alignment check; address used as given, only size=00 goes to ERR.

## Test plan
- MEM_LAT=1, load size=01 addr=0x10 -> mdr_load at cycle 2, rf_write+done+ls_ctrl=01 at cycle 3, mem_addr=0x10 cycles 1-3.
- MEM_LAT=3, store size=11 addr=0x21 -> mdr_load cycle 4, mem_wr+ss_ctrl=11+done cycle 5, exactly one mem_wr pulse.
- Store size=01 addr=0x40 -> mem_wr+ss_ctrl=01+done cycle 1, mdr_load never asserted.
- size=00 -> done+err cycle 1, no mem_wr/rf_write; with `MEM_ALIGN_CHECK_EN`, load size=10 addr=0x03 -> same error response; without it -> normal load.
- reset low during RD_WAIT of a byte store -> all outputs 0 immediately, no mem_wr afterwards; release and new load completes normally.
- start held high 10 cycles, MEM_LAT=1 loads -> done every 4 cycles, start pulses during busy ignored.
